composite_video_gen: RTL
========================

Name: composite_video_gen

Overview:
- Parametrised composite (PAL-style, progressive) video timing and pixel generator.
- Generalises the fixed 640x309 TV-out block:
  - all horizontal and vertical timing as parameters;
  - clock-enable pixel tick instead of a derived clock;
  - multi-bit luma;
  - a pixel-fetch address interface;
  - a built-in test pattern selectable per frame;
  - frame/line strobes and a frame counter.
- Sits between the system clock domain and the external resistor DAC (luma + sync_n).

Parameters:
- CLK_DIV, 5, clk cycles per pixel; valid range 1..16.
- H_TOTAL, 640, pixels per line including blanking.
- H_VISIBLE, 512, visible pixels per line.
- HSYNC_START, 533, first pixel of hsync.
- HSYNC_END, 580, first pixel after hsync.
- V_TOTAL, 309, lines per frame.
- V_VISIBLE, 288, visible lines.
- VSYNC_START, 290, first vsync line.
- VSYNC_LAST, 292, last vsync line; this line carries vsync only for x < H_TOTAL/2.
- PIX_W, 2, luma width in bits.
- X_W, 10, x counter width; must satisfy 2^X_W >= H_TOTAL.
- Y_W, 9, y counter width; must satisfy 2^Y_W >= V_TOTAL.

Ports:
- clk  in  1  system clock (50 MHz nominal).
- rst_n  in  1  asynchronous active-low reset.
- pattern_sel  in  1  1 = internal test pattern, 0 = external pix_data.
- pix_data  in  PIX_W  pixel value for pix_x/pix_y; must be valid at the next pixel tick.
- pix_x  out  X_W  current raster x.
- pix_y  out  Y_W  current raster y.
- pix_req  out  1  high while (pix_x, pix_y) is visible.
- luma  out  PIX_W  video level; 0 = black/blank.
- sync_n  out  1  composite sync, active low.
- blank  out  1  high outside the visible area.
- line_start  out  1  one-clk pulse when x wraps to 0.
- frame_start  out  1  one-clk pulse when (x, y) wraps to (0, 0).
- frame_count  out  8  frames completed, modulo 256.

Behaviour:
- Reset: asynchronous, active-low. All counters and pix_x/pix_y are 0. luma=0, sync_n=1, blank=1, line_start=0, frame_start=0, frame_count=0. The pattern latch is 0.
- Tick: a divider counts 0..CLK_DIV-1. tick=1 on the cycle where the divider equals CLK_DIV-1; with CLK_DIV=1, tick=1 every cycle. All state below updates only on tick cycles.
- Raster:
  - x increments per tick and wraps at H_TOTAL-1 to 0.
  - On that x wrap, y increments and wraps at V_TOTAL-1 to 0.
  - pix_x/pix_y are the counters directly.
- Region decode, evaluated on the current (x, y):
  - visible = x < H_VISIBLE && y < V_VISIBLE.
  - vsync = (VSYNC_START <= y < VSYNC_LAST) || (y == VSYNC_LAST && x < H_TOTAL/2).
  - hsync = HSYNC_START <= x < HSYNC_END, applied on every line including vsync lines.
- pix_req = visible, combinational from the counters.
- Output pipeline, one pixel period latency. On each tick, the output registers load the values for the pre-advance (x, y):
  - blank <= !visible.
  - sync_n <= visible || !(vsync || hsync).
  - luma <= visible ? source : 0.
- Source selection:
  - pattern latch = 0: source is pix_data sampled on that tick.
  - pattern latch = 1: source is the test pattern.
- Test pattern:
  - all ones on the outer border (x == 0, x == H_VISIBLE-1, y == 0, y == V_VISIBLE-1);
  - else 1 where x[4:0] == 0 or y[4:0] == 0;
  - else 0.
- Pattern latch: loads pattern_sel only on the tick where the raster wraps to (0, 0). A mid-frame change never tears a frame.
- Strobes:
  - line_start = 1 for the single clk cycle following a tick that wrapped x to 0.
  - frame_start = 1 likewise, following a tick that wrapped both x and y.
- frame_count increments together with frame_start and wraps 255 -> 0.
- sync_n and luma never assert together: luma is forced to 0 whenever visible == 0.
- Reset asserted mid-line: all outputs return to reset values immediately (asynchronous). After release, the first tick occurs CLK_DIV cycles later with raster (0, 0).

Test Plan:
- Defaults, reset then run 1 line -> line_start period = 3200 clk; sync_n low for 47 ticks starting 533 ticks after line start; blank high for ticks 512..639.
- Full frame, defaults -> frame_start period = 988800 clk.
  - Lines 290-291: sync_n low except during hsync-overlap-free regions, i.e. vsync covers the whole line.
  - Line 292: vsync for x < 320, then normal hsync at 533.
  - frame_count steps by 1 per frame.
- pattern_sel=1 from reset -> luma=3 at visible (0,0), (511,5) and (37,287); luma=1 at (32,7) and (40,64); luma=0 at (33,33); luma=0 everywhere in blanking.
- pattern_sel=0, pix_data driven as a function of pix_x -> luma equals pix_data one pixel period after the address, including at x=511; luma=0 at x=512.
- Toggle pattern_sel mid-frame at y=100 -> no luma change until the next frame_start; the new source applies from (0, 0).
- CLK_DIV=1, H_TOTAL=16, H_VISIBLE=8, V_TOTAL=8, V_VISIBLE=4 (small timing set) -> tick every cycle; frame_start period = 128 clk; rst_n pulsed low mid-frame -> sync_n=1, luma=0, counters restart at (0, 0).

Source files
------------

// File: rtl/composite_video_gen.sv
// rtl/composite_video_gen.sv - parametrised composite video timing and pixel generator
module composite_video_gen #(
  parameter int CLK_DIV     = 5,
  parameter int H_TOTAL     = 640,
  parameter int H_VISIBLE   = 512,
  parameter int HSYNC_START = 533,
  parameter int HSYNC_END   = 580,
  parameter int V_TOTAL     = 309,
  parameter int V_VISIBLE   = 288,
  parameter int VSYNC_START = 290,
  parameter int VSYNC_LAST  = 292,
  parameter int PIX_W       = 2,
  parameter int X_W         = 10,
  parameter int Y_W         = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pattern_sel,
  input  logic [PIX_W-1:0] pix_data,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic             pix_req,
  output logic [PIX_W-1:0] luma,
  output logic             sync_n,
  output logic             blank,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  localparam logic [3:0]     DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [X_W-1:0] X_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] X_VIS      = X_W'(H_VISIBLE);
  localparam logic [X_W-1:0] X_VIS_LAST = X_W'(H_VISIBLE - 1);
  localparam logic [X_W-1:0] X_HS       = X_W'(HSYNC_START);
  localparam logic [X_W-1:0] X_HE       = X_W'(HSYNC_END);
  localparam logic [X_W-1:0] X_HALF     = X_W'(H_TOTAL / 2);
  localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_VIS      = Y_W'(V_VISIBLE);
  localparam logic [Y_W-1:0] Y_VIS_LAST = Y_W'(V_VISIBLE - 1);
  localparam logic [Y_W-1:0] Y_VS       = Y_W'(VSYNC_START);
  localparam logic [Y_W-1:0] Y_VL       = Y_W'(VSYNC_LAST);

  logic [3:0]       div;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             pattern_latch;
  logic             tick;
  logic             x_wrap;
  logic             frame_wrap;
  logic             visible;
  logic             vsync;
  logic             hsync;
  logic [PIX_W-1:0] test_pix;
  logic [PIX_W-1:0] source;

  assign tick       = (div == DIV_LAST);
  assign x_wrap     = tick && (x == X_LAST);
  assign frame_wrap = x_wrap && (y == Y_LAST);

  assign visible = (x < X_VIS) && (y < Y_VIS);
  // The last vsync line is a half line: broad pulse only over its first half.
  assign vsync   = ((y >= Y_VS) && (y < Y_VL)) || ((y == Y_VL) && (x < X_HALF));
  assign hsync   = (x >= X_HS) && (x < X_HE);

  always_comb begin
    test_pix = '0;
    if ((x == '0) || (x == X_VIS_LAST) || (y == '0) || (y == Y_VIS_LAST))
      test_pix = '1;
    else if ((x[4:0] == 5'd0) || (y[4:0] == 5'd0))
      test_pix = PIX_W'(1);
  end

  assign source  = pattern_latch ? test_pix : pix_data;
  assign pix_x   = x;
  assign pix_y   = y;
  assign pix_req = visible;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      x   <= '0;
      y   <= '0;
    end else begin
      div <= tick ? 4'd0 : div + 4'd1;
      if (tick) begin
        x <= (x == X_LAST) ? '0 : x + 1'b1;
        if (x == X_LAST)
          y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end
    end
  end

  // Outputs carry the pixel that was current when the tick fired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luma          <= '0;
      sync_n        <= 1'b1;
      blank         <= 1'b1;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      frame_count   <= '0;
      pattern_latch <= 1'b0;
    end else begin
      line_start  <= x_wrap;
      frame_start <= frame_wrap;
      if (tick) begin
        blank  <= !visible;
        sync_n <= visible || !(vsync || hsync);
        luma   <= visible ? source : '0;
      end
      if (frame_wrap) begin
        frame_count   <= frame_count + 8'd1;
        pattern_latch <= pattern_sel;
      end
    end
  end

endmodule
